lstm_gate_mac: RTL and testbench

LSTM_GATE_MAC -- requirements
Module: lstm_gate_mac

---
 rtl/lstm_gate_mac.sv | 159 +++++++++++++++
 tb/tb_lstm_gate_mac.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_gate_mac.sv
// LSTM gate pre-activation MAC: 4 gates x N_UNITS int8 weights times int8 x, 24-bit saturating accumulators, int8 results.
// Latency: 32 MAC cycles after the input word; first result 1 cycle after leaving MAC or LOAD_B.
// Backpressure: word_ready_o low in MAC/OUT (upstream holds its word); OUT holds data and unit index while out_ready_i is low.
//
// Ports:
//   clk, rstn                                  clock, async active-low reset
//   word_valid_i/word_ready_o/word_data_i      weight, input and bias word stream
//   ts_start_i (with weight word 0)            first chunk of a timestep: clears accumulators, requests biases
//   last_i (with input word)                   last chunk of a timestep: emit results
//   out_valid_o/out_ready_i/out_data_o         per-unit packed int8 results {c, o, i, f}
//   busy_o                                     low only when idle at the start of a weight load
module lstm_gate_mac #(
    parameter int FRAC_SHIFT = 7,
    parameter int N_UNITS    = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    input  logic [31:0] word_data_i,
    input  logic        ts_start_i,
    input  logic        last_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic        busy_o
);

    localparam int            CW        = $clog2(N_UNITS);
    localparam logic [CW-1:0] LAST_UNIT = CW'(N_UNITS - 1);

    typedef enum logic [2:0] {LOAD_W, LOAD_X, MAC, LOAD_B, OUT} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              start_q, last_q;
    logic [7:0]        x_q;
    logic [31:0]       wbuf [N_UNITS];
    logic [23:0]       acc  [4][N_UNITS];
    logic [31:0]       w_sel;
    logic signed [15:0] prod [4];
    logic              in_xfer, out_xfer, cnt_end, cnt_adv;

    // Add with clamping to the signed 24-bit range instead of wrapping.
    function automatic logic [23:0] sat_add(input logic [23:0] a, input logic [23:0] b);
        logic [24:0] s;
        s = {a[23], a} + {b[23], b};
        if (s[24] != s[23])
            sat_add = s[24] ? 24'h800000 : 24'h7FFFFF;
        else
            sat_add = s[23:0];
    endfunction

    // Rescale by FRAC_SHIFT, then clamp to int8.
    function automatic logic [7:0] sat8(input logic [23:0] v);
        logic signed [23:0] sh;
        sh = $signed(v) >>> FRAC_SHIFT;
        if (sh > 24'sd127)
            sat8 = 8'h7F;
        else if (sh < -24'sd128)
            sat8 = 8'h80;
        else
            sat8 = sh[7:0];
    endfunction

    // Ready is gated by rstn so it reads 0 while reset is held.
    assign word_ready_o = rstn && (state == LOAD_W || state == LOAD_X || state == LOAD_B);
    assign out_valid_o  = (state == OUT);
    assign busy_o       = !(state == LOAD_W && cnt == '0);
    assign in_xfer      = word_valid_i && word_ready_o;
    assign out_xfer     = out_valid_o && out_ready_i;
    assign cnt_end      = (cnt == LAST_UNIT);
    // LOAD_X is a single word and leaves the unit counter at 0 for MAC.
    assign cnt_adv      = (in_xfer && state != LOAD_X) || state == MAC || out_xfer;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= LOAD_W;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (cnt_adv)
                cnt <= cnt_end ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD_W:  if (in_xfer && cnt_end) state_nxt = LOAD_X;
            LOAD_X:  if (in_xfer) state_nxt = MAC;
            MAC:     if (cnt_end) state_nxt = start_q ? LOAD_B : (last_q ? OUT : LOAD_W);
            LOAD_B:  if (in_xfer && cnt_end) state_nxt = last_q ? OUT : LOAD_W;
            OUT:     if (out_xfer && cnt_end) state_nxt = LOAD_W;
            default: state_nxt = LOAD_W;
        endcase
    end

    // Weight buffer is always fully rewritten before use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == LOAD_W && in_xfer)
            wbuf[cnt] <= word_data_i;
    end

    assign w_sel = wbuf[cnt];

    always_comb begin
        for (int g = 0; g < 4; g++)
            prod[g] = $signed({{8{w_sel[8*g+7]}}, w_sel[8*g +: 8]}) * $signed({{8{x_q[7]}}, x_q});
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_q <= 1'b0;
            last_q  <= 1'b0;
            x_q     <= '0;
            for (int g = 0; g < 4; g++)
                for (int n = 0; n < N_UNITS; n++)
                    acc[g][n] <= '0;
        end else begin
            case (state)
                LOAD_W: begin
                    if (in_xfer && cnt == '0) begin
                        start_q <= ts_start_i;
                        if (ts_start_i)
                            for (int g = 0; g < 4; g++)
                                for (int n = 0; n < N_UNITS; n++)
                                    acc[g][n] <= '0;
                    end
                end
                LOAD_X: begin
                    if (in_xfer) begin
                        x_q    <= word_data_i[7:0];
                        last_q <= last_i;
                    end
                end
                MAC: begin
                    for (int g = 0; g < 4; g++)
                        acc[g][cnt] <= sat_add(acc[g][cnt], {{8{prod[g][15]}}, prod[g]});
                end
                LOAD_B: begin
                    if (in_xfer)
                        for (int g = 0; g < 4; g++)
                            acc[g][cnt] <= sat_add(acc[g][cnt],
                                                   {{16{word_data_i[8*g+7]}}, word_data_i[8*g +: 8]});
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_data_o = '0;
        if (state == OUT)
            for (int g = 0; g < 4; g++)
                out_data_o[8*g +: 8] = sat8(acc[g][cnt]);
    end

endmodule

// File: tb/tb_lstm_gate_mac.sv
// Testbench for lstm_gate_mac: two instances (FRAC_SHIFT 0 and 7) share one stimulus stream.
// Expected results come from an integer accumulator model of the gate arithmetic.
// Prints one TB_RESULT summary line.
module tb_lstm_gate_mac;

    logic        clk = 1'b0;
    logic        rstn;
    logic        word_valid_i;
    logic [31:0] word_data_i;
    logic        ts_start_i;
    logic        last_i;
    logic        out_ready_i;
    logic        rdy0, vld0, busy0, rdy7, vld7, busy7;
    logic [31:0] dat0, dat7;

    int checks   = 0;
    int failures = 0;

    int          macc [4][32];
    logic [31:0] wts  [32];
    logic [31:0] bias [32];

    always #5 clk = ~clk;

    lstm_gate_mac #(.FRAC_SHIFT(0), .N_UNITS(32)) dut0 (
        .clk(clk), .rstn(rstn),
        .word_valid_i(word_valid_i), .word_ready_o(rdy0), .word_data_i(word_data_i),
        .ts_start_i(ts_start_i), .last_i(last_i),
        .out_valid_o(vld0), .out_ready_i(out_ready_i), .out_data_o(dat0), .busy_o(busy0)
    );

    lstm_gate_mac #(.FRAC_SHIFT(7), .N_UNITS(32)) dut7 (
        .clk(clk), .rstn(rstn),
        .word_valid_i(word_valid_i), .word_ready_o(rdy7), .word_data_i(word_data_i),
        .ts_start_i(ts_start_i), .last_i(last_i),
        .out_valid_o(vld7), .out_ready_i(out_ready_i), .out_data_o(dat7), .busy_o(busy7)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int sat24(input int v);
        if (v > 8388607)  return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    task automatic model_clear();
        for (int g = 0; g < 4; g++)
            for (int n = 0; n < 32; n++)
                macc[g][n] = 0;
    endtask

    function automatic logic [31:0] exp_word(input int shift, input int n);
        logic [31:0] r;
        int v;
        r = '0;
        for (int g = 0; g < 4; g++) begin
            v = macc[g][n] >>> shift;
            if (v > 127)       v = 127;
            else if (v < -128) v = -128;
            r[8*g +: 8] = v[7:0];
        end
        return r;
    endfunction

    task automatic fill(input logic [31:0] w, input logic [31:0] b);
        for (int n = 0; n < 32; n++) begin
            wts[n]  = w;
            bias[n] = b;
        end
    endtask

    task automatic fill_rand();
        for (int n = 0; n < 32; n++) begin
            wts[n]  = $urandom();
            bias[n] = $urandom();
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_word(input logic [31:0] d, input bit ts, input bit lst, input int max_gap);
        int n;
        bit r;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        @(negedge clk);
        word_valid_i = 1'b1;
        word_data_i  = d;
        ts_start_i   = ts;
        last_i       = lst;
        n = 0;
        forever begin
            r = rdy0;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 200) begin
                check_val("in_timeout", {31'b0, r}, 32'd1);
                break;
            end
            @(negedge clk);
        end
        word_valid_i = 1'b0;
    endtask

    task automatic collect(input int mode);
        int idx, waited, stalls;
        bit prev_stall;
        logic [31:0] prev;
        idx = 0; waited = 0; stalls = 0; prev_stall = 0; prev = '0;
        while (idx < 32 && waited < 3000) begin
            @(negedge clk);
            waited++;
            case (mode)
                0: out_ready_i = 1'b1;
                1: out_ready_i = ($urandom_range(0, 3) != 0);
                default: begin
                    if (idx == 3 && stalls < 5) begin
                        out_ready_i = 1'b0;
                        stalls++;
                    end else begin
                        out_ready_i = 1'b1;
                    end
                end
            endcase
            if (vld0) begin
                if (prev_stall) check_val("hold", dat0, prev);
                if (out_ready_i) begin
                    check_val("out_fs0", dat0, exp_word(0, idx));
                    check_val("out_fs7", dat7, exp_word(7, idx));
                    idx++;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    prev = dat0;
                end
            end
        end
        if (idx < 32) check_val("out_timeout", idx, 32'd32);
        @(negedge clk);
        out_ready_i = 1'b0;
        check_val("post_out_vld", {30'b0, vld0, vld7}, 32'd0);
        check_val("post_out_busy", {30'b0, busy0, busy7}, 32'd0);
    endtask

    task automatic run_chunk(input bit ts, input bit lst, input logic [7:0] x,
                             input int max_gap, input int bp_mode);
        logic signed [7:0] wb, xs, bb;
        logic [31:0] xw;
        int lat;
        xs = x;
        if (ts) model_clear();
        for (int n = 0; n < 32; n++)
            for (int g = 0; g < 4; g++) begin
                wb = wts[n][8*g +: 8];
                macc[g][n] = sat24(macc[g][n] + wb * xs);
            end
        for (int n = 0; n < 32; n++)
            send_word(wts[n], (n == 0) ? ts : bit'($urandom_range(0, 1)),
                      bit'($urandom_range(0, 1)), max_gap);
        xw = $urandom();
        xw[7:0] = x;
        send_word(xw, bit'($urandom_range(0, 1)), lst, max_gap);
        // Offer a junk word during MAC; it must not be taken.
        word_valid_i = 1'b1;
        word_data_i  = $urandom();
        lat = 0;
        forever begin
            @(negedge clk);
            if (rdy0 || vld0 || lat >= 200) break;
            lat++;
        end
        word_valid_i = 1'b0;
        check_val("mac_lat", lat, 32'd32);
        if (ts) begin
            for (int n = 0; n < 32; n++) begin
                for (int g = 0; g < 4; g++) begin
                    bb = bias[n][8*g +: 8];
                    macc[g][n] = sat24(macc[g][n] + bb);
                end
                send_word(bias[n], bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), max_gap);
            end
        end
        if (lst) collect(bp_mode);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int nch;
        word_valid_i = 1'b0;
        word_data_i  = '0;
        ts_start_i   = 1'b0;
        last_i       = 1'b0;
        out_ready_i  = 1'b0;
        rstn = 1'b1;
        #3 rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_rdy",  {30'b0, rdy0, rdy7}, 32'd0);
        check_val("rst_vld",  {30'b0, vld0, vld7}, 32'd0);
        check_val("rst_dat",  dat0 | dat7, 32'd0);
        check_val("rst_busy", {30'b0, busy0, busy7}, 32'd0);
        rstn = 1'b1;
        #1;
        check_val("rdy_after_rst", {30'b0, rdy0, rdy7}, 32'd3);
        model_clear();

        // Single chunk, x=2, bias 3 -> 5 per gate at FRAC_SHIFT 0.
        fill(32'h01010101, 32'h03030303);
        run_chunk(1'b1, 1'b1, 8'h02, 0, 0);

        // Three chunks of 127*127 -> 48387, clamps to 127 after >>>7.
        fill(32'h7F7F7F7F, 32'h00000000);
        run_chunk(1'b1, 1'b0, 8'h7F, 0, 0);
        run_chunk(1'b0, 1'b0, 8'h7F, 0, 0);
        run_chunk(1'b0, 1'b1, 8'h7F, 0, 0);

        // Two chunks of -128*127 -> -32512, clamps to -128.
        fill(32'h80808080, 32'h00000000);
        run_chunk(1'b1, 1'b0, 8'h7F, 0, 0);
        run_chunk(1'b0, 1'b1, 8'h7F, 0, 0);

        // Output stall of 5 cycles at unit 3.
        fill(32'h01010101, 32'h03030303);
        run_chunk(1'b1, 1'b1, 8'h02, 0, 2);

        // Reset at MAC cycle 10 discards the timestep.
        fill(32'h01010101, 32'h03030303);
        for (int n = 0; n < 32; n++) send_word(wts[n], n == 0, 1'b0, 0);
        send_word(32'h00000002, 1'b0, 1'b1, 0);
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        #1;
        check_val("midmac_rst_vld", {30'b0, vld0, rdy0}, 32'd0);
        check_val("midmac_rst_dat", dat0, 32'd0);
        model_clear();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check_val("midmac_rdy", {31'b0, rdy0}, 32'd1);
        run_chunk(1'b1, 1'b1, 8'h02, 0, 0);

        // Back-to-back timesteps: second one must start from cleared accumulators.
        fill(32'h01010101, 32'h03030303);
        run_chunk(1'b1, 1'b1, 8'h02, 0, 0);
        run_chunk(1'b1, 1'b1, 8'h01, 0, 0);

        // Randomized timesteps with input gaps and output backpressure.
        repeat (5) begin
            nch = $urandom_range(1, 3);
            for (int c = 0; c < nch; c++) begin
                fill_rand();
                run_chunk(c == 0, c == nch - 1, 8'($urandom()), 1, 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
